// File: rtl/regbank.sv
// regbank: small register file with per-register valid flags and a LIFO save
// stack. Registers are written from one of three sources (or cleared), saved
// to the stack with push and restored with pop. Reads are combinational on rSel.
module regbank #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             iInbox,
    input  logic [WIDTH-1:0]             iMem,
    input  logic [WIDTH-1:0]             iAlu,
    input  logic [1:0]                   muxR,
    input  logic                         wR,
    input  logic [$clog2(NREGS)-1:0]     rSel,
    input  logic                         push,
    input  logic                         pop,
    output logic signed [WIDTH-1:0]      R,
    output logic                         V,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err
);

    localparam int LVLW = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] SRC_INBOX = 2'b00;
    localparam logic [1:0] SRC_MEM   = 2'b01;
    localparam logic [1:0] SRC_CLEAR = 2'b10;
    localparam logic [1:0] SRC_ALU   = 2'b11;

    logic [WIDTH-1:0] val_q     [NREGS];
    logic             vld_q     [NREGS];
    logic [WIDTH-1:0] stk_val_q [DEPTH];
    logic             stk_vld_q [DEPTH];
    logic [LVLW-1:0]  level_q, level_d;
    logic             err_q, err_d;

    logic             sel_ok;
    logic [WIDTH-1:0] cur_val;
    logic             cur_vld;
    logic [WIDTH-1:0] wr_val;
    logic             wr_vld;
    logic             full_w, empty_w;
    logic             do_push, do_pop, do_wr, err_set;
    logic [LVLW-1:0]  lvl_dec;
    logic [AW-1:0]    push_idx, top_idx;

    // Selected register lookup; out-of-range selects read as an empty register
    always_comb begin
        sel_ok  = (int'(rSel) < NREGS);
        cur_val = '0;
        cur_vld = 1'b0;
        if (sel_ok) begin
            cur_val = val_q[rSel];
            cur_vld = vld_q[rSel];
        end
    end

    assign R     = $signed(cur_val);
    assign V     = cur_vld;
    assign full  = full_w;
    assign empty = empty_w;
    assign level = level_q;
    assign err   = err_q;

    // Write source selection; the clear code also drops the valid flag
    always_comb begin
        wr_val = '0;
        wr_vld = 1'b0;
        case (muxR)
            SRC_INBOX: begin wr_val = iInbox; wr_vld = 1'b1; end
            SRC_MEM:   begin wr_val = iMem;   wr_vld = 1'b1; end
            SRC_ALU:   begin wr_val = iAlu;   wr_vld = 1'b1; end
            SRC_CLEAR: begin wr_val = '0;     wr_vld = 1'b0; end
            default:   begin wr_val = '0;     wr_vld = 1'b0; end
        endcase
    end

    // Operation decode: a push and pop together cancel each other, and a
    // performed pop takes the register port so a same-cycle write is dropped
    always_comb begin
        full_w   = (level_q == LVLW'(DEPTH));
        empty_w  = (level_q == '0);
        lvl_dec  = level_q - LVLW'(1);
        push_idx = level_q[AW-1:0];
        top_idx  = lvl_dec[AW-1:0];
        do_push  = push & ~pop & ~full_w  & sel_ok;
        do_pop   = pop  & ~push & ~empty_w & sel_ok;
        do_wr    = wR   & sel_ok & ~do_pop;
        err_set  = (~sel_ok & (wR | push | pop))
                 | (push & pop)
                 | (push & ~pop & full_w)
                 | (pop & ~push & empty_w)
                 | (pop & wR);
        level_d  = level_q;
        if (do_push) begin
            level_d = level_q + LVLW'(1);
        end else if (do_pop) begin
            level_d = lvl_dec;
        end
        err_d = err_q | err_set;
    end

    // Register file: restore from stack top has priority over a write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                val_q[i] <= '0;
                vld_q[i] <= 1'b0;
            end
        end else if (do_pop) begin
            val_q[rSel] <= stk_val_q[top_idx];
            vld_q[rSel] <= stk_vld_q[top_idx];
        end else if (do_wr) begin
            val_q[rSel] <= wr_val;
            vld_q[rSel] <= wr_vld;
        end
    end

    // Stack storage captures the register as it was before this edge
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            stk_val_q[push_idx] <= cur_val;
            stk_vld_q[push_idx] <= cur_vld;
        end
    end

    // Stack occupancy and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_regbank.sv
// tb_regbank: scenario tasks plus randomized traffic, checked against a
// queue-based reference model of the register bank.
module tb_regbank;
    localparam int WIDTH = 8;
    localparam int NREGS = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  iInbox = '0, iMem = '0, iAlu = '0;
    logic [1:0]        muxR = 2'b00;
    logic              wR = 1'b0;
    logic [1:0]        rSel = 2'b00;
    logic              push = 1'b0, pop = 1'b0;
    logic signed [WIDTH-1:0] R;
    logic              V, full, empty, err;
    logic [2:0]        level;

    int ncheck = 0;
    int nfail  = 0;

    // reference model state
    logic [7:0] mval [NREGS];
    bit         mvld [NREGS];
    logic [8:0] mstk [$];
    bit         merr;

    regbank #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .iInbox(iInbox), .iMem(iMem), .iAlu(iAlu),
        .muxR(muxR), .wR(wR), .rSel(rSel), .push(push), .pop(pop),
        .R(R), .V(V), .full(full), .empty(empty), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    // expected {R,V,full,empty,level,err} for register sel
    function automatic logic [14:0] exp_bus(input int sel);
        bit         f  = (mstk.size() == DEPTH);
        bit         e  = (mstk.size() == 0);
        logic [2:0] lv = 3'(mstk.size());
        return {mval[sel], mvld[sel], f, e, lv, merr};
    endfunction

    // drive one cycle and advance the model by the block's rules
    task automatic step(input bit r, input logic [1:0] mx, input bit w, input int sel,
                        input bit pu, input bit po,
                        input logic [7:0] inb, input logic [7:0] mem, input logic [7:0] alu);
        logic [8:0] e;
        bit wr_ok;
        rst = r; muxR = mx; wR = w; rSel = 2'(sel); push = pu; pop = po;
        iInbox = inb; iMem = mem; iAlu = alu;
        @(posedge clk);
        wr_ok = w;
        if (r) begin
            for (int i = 0; i < NREGS; i++) begin mval[i] = '0; mvld[i] = 0; end
            mstk.delete();
            merr = 0;
        end else begin
            if (pu && po) merr = 1;
            else if (pu) begin
                if (mstk.size() == DEPTH) merr = 1;
                else mstk.push_back({mvld[sel], mval[sel]});
            end else if (po) begin
                if (mstk.size() == 0) merr = 1;
                else begin
                    e = mstk.pop_back();
                    mvld[sel] = e[8];
                    mval[sel] = e[7:0];
                    wr_ok = 0;
                end
            end
            if (po && w) merr = 1;
            if (wr_ok) begin
                if (mx == 2'b10) begin
                    mval[sel] = '0; mvld[sel] = 0;
                end else begin
                    mval[sel] = (mx == 2'b00) ? inb : (mx == 2'b01) ? mem : alu;
                    mvld[sel] = 1;
                end
            end
        end
        #1;
        rst = 0; wR = 0; push = 0; pop = 0;
    endtask

    // write d through source mx; unselected sources carry different data
    task automatic wr(input logic [1:0] mx, input int sel, input logic [7:0] d);
        step(0, mx, 1, sel, 0, 0, (mx == 2'b00) ? d : ~d,
             (mx == 2'b01) ? d : d ^ 8'h3C, (mx == 2'b11) ? d : d + 8'd7);
    endtask

    task automatic do_push(input int sel);
        step(0, 2'b00, 0, sel, 1, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_pop(input int sel);
        step(0, 2'b00, 0, sel, 0, 1, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        step(1, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        wr(2'b00, 1, 8'h77);
        do_push(1);
        step(1, 2'b11, 1, 2, 1, 0, 8'h12, 8'h34, 8'h56);
        for (int s = 0; s < NREGS; s++) begin
            rSel = 2'(s); #1;
            if ({R, V, full, empty, level, err} !== 15'h0010) begin
                nfail++;
                $display("FAIL reset_state sel=%0d: got %h want %h", s, {R, V, full, empty, level, err}, 15'h0010);
            end
            ncheck++;
        end
    endtask

    task automatic test_write_clear();
        do_reset();
        wr(2'b00, 0, 8'h5A);
        if (R !== 8'sh5A || V !== 1'b1) begin
            nfail++; $display("FAIL write_inbox: got R=%h V=%b want 5a 1", R, V);
        end
        ncheck++;
        step(0, 2'b10, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        if (R !== 8'sh00 || V !== 1'b0) begin
            nfail++; $display("FAIL write_clear: got R=%h V=%b want 00 0", R, V);
        end
        ncheck++;
        wr(2'b01, 2, 8'hC3);
        if ({R, V, full, empty, level, err} !== exp_bus(2)) begin
            nfail++; $display("FAIL write_mem: got %h want %h", {R, V, full, empty, level, err}, exp_bus(2));
        end
        ncheck++;
    endtask

    task automatic test_push_pop();
        do_reset();
        wr(2'b11, 1, 8'h80);
        do_push(1);
        if (level !== 3'd1 || empty !== 1'b0) begin
            nfail++; $display("FAIL push_level: got level=%0d empty=%b want 1 0", level, empty);
        end
        ncheck++;
        wr(2'b01, 1, 8'h01);
        if (R !== 8'sh01) begin
            nfail++; $display("FAIL overwrite: got R=%h want 01", R);
        end
        ncheck++;
        do_pop(1);
        if (R !== -8'sd128 || V !== 1'b1 || level !== 3'd0 || err !== 1'b0) begin
            nfail++; $display("FAIL pop_restore: got R=%0d V=%b level=%0d err=%b want -128 1 0 0", R, V, level, err);
        end
        ncheck++;
    endtask

    task automatic test_fill();
        logic [7:0] saved [DEPTH];
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            saved[k] = 8'($urandom);
            wr(2'b00, k, saved[k]);
            do_push(k);
            if (level !== 3'(k + 1) || full !== (k == DEPTH - 1) || err !== 1'b0) begin
                nfail++; $display("FAIL fill_%0d: got level=%0d full=%b err=%b want %0d %b 0", k, level, full, err, k + 1, k == DEPTH - 1);
            end
            ncheck++;
        end
        do_push(0);
        if (level !== 3'd4 || full !== 1'b1 || err !== 1'b1) begin
            nfail++; $display("FAIL push_full: got level=%0d full=%b err=%b want 4 1 1", level, full, err);
        end
        ncheck++;
        for (int j = 0; j < DEPTH; j++) begin
            do_pop(0);
            if (R !== $signed(saved[DEPTH - 1 - j]) || V !== 1'b1 || level !== 3'(DEPTH - 1 - j)) begin
                nfail++; $display("FAIL lifo_%0d: got R=%h V=%b level=%0d want %h 1 %0d", j, R, V, level, saved[DEPTH - 1 - j], DEPTH - 1 - j);
            end
            ncheck++;
        end
        if (empty !== 1'b1 || full !== 1'b0) begin
            nfail++; $display("FAIL drained: got empty=%b full=%b want 1 0", empty, full);
        end
        ncheck++;
    endtask

    task automatic test_pop_empty();
        do_reset();
        wr(2'b00, 2, 8'h3E);
        do_pop(2);
        if (R !== 8'sh3E || V !== 1'b1 || level !== 3'd0 || err !== 1'b1) begin
            nfail++; $display("FAIL pop_empty: got R=%h V=%b level=%0d err=%b want 3e 1 0 1", R, V, level, err);
        end
        ncheck++;
        wr(2'b01, 1, 8'h10);
        do_push(1);
        do_pop(3);
        if (err !== 1'b1) begin
            nfail++; $display("FAIL err_sticky: got err=%b want 1", err);
        end
        ncheck++;
        do_reset();
        if (err !== 1'b0) begin
            nfail++; $display("FAIL err_clear: got err=%b want 0", err);
        end
        ncheck++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr(2'b00, 3, 8'h11);
        step(0, 2'b11, 1, 3, 1, 0, 8'hAA, 8'hBB, 8'h22);
        if (R !== 8'sh22 || level !== 3'd1 || err !== 1'b0) begin
            nfail++; $display("FAIL push_write: got R=%h level=%0d err=%b want 22 1 0", R, level, err);
        end
        ncheck++;
        do_pop(3);
        if (R !== 8'sh11 || level !== 3'd0) begin
            nfail++; $display("FAIL push_write_restore: got R=%h level=%0d want 11 0", R, level);
        end
        ncheck++;
        do_push(3);
        step(0, 2'b00, 1, 3, 1, 1, 8'h99, 8'h00, 8'h00);
        if (R !== 8'sh99 || level !== 3'd1 || err !== 1'b1) begin
            nfail++; $display("FAIL push_and_pop: got R=%h level=%0d err=%b want 99 1 1", R, level, err);
        end
        ncheck++;
        do_reset();
        wr(2'b00, 0, 8'h44);
        do_push(0);
        step(0, 2'b00, 1, 0, 0, 1, 8'h55, 8'h00, 8'h00);
        if (R !== 8'sh44 || level !== 3'd0 || err !== 1'b1) begin
            nfail++; $display("FAIL pop_with_write: got R=%h level=%0d err=%b want 44 0 1", R, level, err);
        end
        ncheck++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr(2'b11, k, 8'(k + 8'hA0));
            do_push(k);
        end
        step(1, 2'b00, 1, 1, 1, 0, 8'hEE, 8'hEE, 8'hEE);
        if (level !== 3'd0 || empty !== 1'b1 || err !== 1'b0) begin
            nfail++; $display("FAIL reset_mid: got level=%0d empty=%b err=%b want 0 1 0", level, empty, err);
        end
        ncheck++;
        for (int s = 0; s < NREGS; s++) begin
            rSel = 2'(s); #1;
            if (V !== 1'b0 || R !== 8'sh00) begin
                nfail++; $display("FAIL reset_mid_reg%0d: got R=%h V=%b want 00 0", s, R, V);
            end
            ncheck++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int sel = $urandom_range(0, NREGS - 1);
            bit r   = ($urandom_range(0, 79) == 0);
            step(r, 2'($urandom), ($urandom_range(0, 2) != 0), sel,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), 8'($urandom), 8'($urandom));
            if ({R, V, full, empty, level, err} !== exp_bus(sel)) begin
                nfail++; $display("FAIL random_%0d: got %h want %h", n, {R, V, full, empty, level, err}, exp_bus(sel));
            end
            ncheck++;
            if (n % 25 == 0) begin
                for (int s = 0; s < NREGS; s++) begin
                    rSel = 2'(s); #1;
                    if ({R, V, full, empty, level, err} !== exp_bus(s)) begin
                        nfail++; $display("FAIL random_scan_%0d_reg%0d: got %h want %h", n, s, {R, V, full, empty, level, err}, exp_bus(s));
                    end
                    ncheck++;
                end
            end
        end
    endtask

    initial begin
        merr = 0;
        test_reset();
        test_write_clear();
        test_push_pop();
        test_fill();
        test_pop_empty();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule

// File: doc/regbank.md
REGBANK -- requirements
Module: regbank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and data input.
REQ-002 Parameter NREGS, default 4, number of registers (>=2).
REQ-003 Parameter DEPTH, default 4, save-stack entries (>=1).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 iInbox  input  WIDTH  inbox data source.
REQ-007 iMem  input  WIDTH  memory data source.
REQ-008 iAlu  input  WIDTH  ALU result source.
REQ-009 muxR  input  2  write source select: 00 inbox, 01 mem, 11 alu, 10 clear.
REQ-010 wR  input  1  write enable for selected register.
REQ-011 rSel  input  $clog2(NREGS)  selected register for write, push, pop and read.
REQ-012 push  input  1  save selected register onto stack.
REQ-013 pop  input  1  restore top of stack into selected register.
REQ-014 R  output  WIDTH, signed  value of register rSel, combinational read.
REQ-015 V  output  1  valid flag of register rSel ("hands not empty"), combinational.
REQ-016 full  output  1  stack holds DEPTH entries.
REQ-017 empty  output  1  stack holds 0 entries.
REQ-018 level  output  $clog2(DEPTH+1)  current stack occupancy.
REQ-019 err  output  1  sticky error flag.

Function
REQ-020 Each register stores WIDTH-bit value plus 1-bit valid flag.
REQ-021 wR=1, muxR in {00,01,11}: reg[rSel] <= source, valid <= 1, visible on R/V next cycle.
REQ-022 wR=1, muxR=10: reg[rSel] <= 0, valid <= 0.
REQ-023 wR=0: no register changes except by pop.
REQ-024 rSel >= NREGS (non-power-of-2 NREGS): write/push/pop ignored, err <= 1, R=0, V=0.
REQ-025 Stack entry = {valid, value}; LIFO; level increments on push, decrements on pop.
REQ-026 push=1, pop=0, not full: stack[level] <= {valid,value} of reg[rSel] as held BEFORE this edge; level+1.
REQ-027 push with wR same cycle: old value pushed, new value written to register; both take effect.
REQ-028 pop=1, push=0, not empty: reg[rSel] <= top entry (value and valid); level-1.
REQ-029 pop with wR same cycle: pop wins, write discarded, err <= 1.
REQ-030 push and pop same cycle: neither performed, level unchanged, err <= 1; wR still honoured.
REQ-031 push when full: ignored, level stays DEPTH, err <= 1; wR still honoured.
REQ-032 pop when empty: ignored, register unchanged, err <= 1; wR still honoured.
REQ-033 full = (level==DEPTH); empty = (level==0); both derived from registered level.
REQ-034 err sticky; cleared only by rst.
REQ-035 Single-cycle latency for all operations; no handshake stall; block always accepts.

Reset
REQ-036 rst=1 at posedge: all registers value 0, valid 0; level 0; err 0; stack contents don't-care.
REQ-037 Reset takes priority over wR/push/pop asserted same cycle; in-flight operations discarded.
REQ-038 After reset: R=0, V=0, empty=1, full=0, level=0, err=0 for any rSel.

Verification
REQ-039 Reset, rSel=0, wR=1, muxR=00, iInbox=8'h5A -> next cycle R=5A, V=1; then muxR=10 -> R=00, V=0.
REQ-040 Write reg1=8'h80 via alu, push, write reg1=8'h01 via mem, pop -> R=8'h80 (signed -128), V=1, level 1->0, err=0.
REQ-041 DEPTH=4: five pushes -> level=4, full=1 after 4th, 5th sets err=1, level stays 4; four pops return pushed values in reverse order, empty=1.
REQ-042 Pop on empty stack -> register unchanged, level 0, err=1; err stays 1 until rst.
REQ-043 Same cycle push+wR (reg=0x11, iAlu=0x22) -> reg=0x22, pop later restores 0x11; push+pop same cycle -> level unchanged, err=1.
REQ-044 Assert rst mid-sequence with level=3 and push=1 -> next cycle level=0, empty=1, all V=0, err=0.
